// File: rtl/ti_adc_pkg.sv
// Shared constants, frame-collector state type and sample helpers for the TI-ADC blocks.
package ti_adc_pkg;

    localparam int DEF_ADC_WAYS   = 8;
    localparam int DEF_ADC_BITS   = 9;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int MAX_BITS       = 16;
    localparam int IDX_W          = $clog2(MAX_BITS);
    localparam int SW             = MAX_BITS + 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Reverses the low 'width' bits of value; bits above width come back as zero.
    function automatic logic [MAX_BITS-1:0] bit_reverse(input logic [MAX_BITS-1:0] value,
                                                        input int width);
        logic [MAX_BITS-1:0] result;
        logic [IDX_W-1:0]    src;
        result = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            src = IDX_W'(width - 1 - i);
            if (i < width) result[i] = value[src];
        end
        return result;
    endfunction

    // Clamps a signed value into the two's-complement range of 'width' bits.
    function automatic logic [MAX_BITS-1:0] sat_signed(input logic signed [SW-1:0] value,
                                                       input int width);
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = SW'((1 <<< (width - 1)) - 1);
        lo = ~hi;
        if (value > hi) return MAX_BITS'(hi);
        if (value < lo) return MAX_BITS'(lo);
        return MAX_BITS'(value);
    endfunction

endpackage

// File: rtl/ti_adc_frame_fifo.sv
// Parametrised synchronous FIFO with full/empty flags and a zeroed head while empty.
module ti_adc_frame_fifo
    import ti_adc_pkg::*;
#(
    parameter int WIDTH = DEF_ADC_WAYS * DEF_ADC_BITS,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells a wrapped-full FIFO apart from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ti_adc_frame_retimer.sv
// Gathers one sample per sub-ADC way into a frame and queues whole frames for the DSP.
// Define TI_ADC_FRAME_OFFSET_EN to add signed conversion and per-way offset removal.
module ti_adc_frame_retimer
    import ti_adc_pkg::*;
#(
    parameter int ADC_WAYS   = DEF_ADC_WAYS,
    parameter int ADC_BITS   = DEF_ADC_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = 32,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         msb_first,
    input  logic [ADC_WAYS-1:0]          way_valid,
    input  logic [ADC_WAYS*ADC_BITS-1:0] way_data,
`ifdef TI_ADC_FRAME_OFFSET_EN
    input  logic [ADC_WAYS*ADC_BITS-1:0] way_offset,
    input  logic                         offset_bypass,
`endif
    input  logic                         frame_ready,
    output logic                         frame_valid,
    output logic [ADC_WAYS*ADC_BITS-1:0] frame_data,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             drop_cnt,
    input  logic                         err_clr,
    output logic                         err_missing,
    output logic                         err_dup,
    output logic                         err_ovf
);

    localparam int FW = ADC_WAYS * ADC_BITS;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [TW-1:0]       timer;
    logic [ADC_WAYS-1:0] captured;
    logic [ADC_WAYS-1:0] accept;
    logic [ADC_WAYS-1:0] dup;
    logic [FW-1:0]       slots;
    logic [FW-1:0]       next_slots;
    logic [FW-1:0]       cap_val;
    logic                complete;
    logic                timeout;
    logic                pop;
    logic                full;
    logic                empty;
    logic                drop;

    assign accept      = en ? (way_valid & ~captured) : '0;
    assign dup         = en ? (way_valid & captured) : '0;
    assign frame_valid = ~empty;
    assign pop         = frame_valid & frame_ready;

    for (genvar k = 0; k < ADC_WAYS; k++) begin : g_way
        logic [ADC_BITS-1:0] raw;
        logic [ADC_BITS-1:0] ordered;
        assign raw     = way_data[k*ADC_BITS +: ADC_BITS];
        assign ordered = msb_first ? ADC_BITS'(bit_reverse(MAX_BITS'(raw), ADC_BITS)) : raw;
`ifdef TI_ADC_FRAME_OFFSET_EN
        // Offset-binary becomes signed by flipping the MSB; one guard bit absorbs the subtraction.
        logic signed [ADC_BITS:0] centred;
        logic signed [ADC_BITS:0] way_off;
        logic signed [ADC_BITS:0] diff;
        assign centred = $signed({~ordered[ADC_BITS-1], ~ordered[ADC_BITS-1], ordered[ADC_BITS-2:0]});
        assign way_off = $signed({way_offset[k*ADC_BITS+ADC_BITS-1], way_offset[k*ADC_BITS +: ADC_BITS]});
        assign diff    = offset_bypass ? centred : centred - way_off;
        assign cap_val[k*ADC_BITS +: ADC_BITS] = ADC_BITS'(sat_signed(SW'(diff), ADC_BITS));
`else
        assign cap_val[k*ADC_BITS +: ADC_BITS] = ordered;
`endif
    end

    always_comb begin
        next_slots = slots;
        for (int k = 0; k < ADC_WAYS; k++) begin
            if (accept[k]) next_slots[k*ADC_BITS +: ADC_BITS] = cap_val[k*ADC_BITS +: ADC_BITS];
        end
    end

    // Timeout wins over completion so strobes in the expiry cycle die with the partial frame.
    always_comb begin
        complete = 1'b0;
        timeout  = 1'b0;
        if (state == COLLECT && timer == TW'(TIMEOUT)) begin
            timeout = 1'b1;
        end else if ((|accept) && ((captured | accept) == '1)) begin
            complete = 1'b1;
        end
    end

    assign drop = complete & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            captured <= '0;
            slots    <= '0;
        end else if (timeout || complete) begin
            state    <= IDLE;
            timer    <= '0;
            captured <= '0;
        end else if (state == IDLE) begin
            if (|accept) begin
                state    <= COLLECT;
                timer    <= TW'(1);
                captured <= accept;
                slots    <= next_slots;
            end
        end else begin
            timer    <= timer + TW'(1);
            captured <= captured | accept;
            slots    <= next_slots;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            err_missing <= 1'b0;
            err_dup     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            if (complete && !drop) frame_cnt <= frame_cnt + CNT_W'(1);
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            err_missing <= (err_missing & ~err_clr) | timeout;
            err_dup     <= (err_dup & ~err_clr) | (|dup);
            err_ovf     <= (err_ovf & ~err_clr) | drop;
        end
    end

    ti_adc_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (complete),
        .push_data (next_slots),
        .pop       (pop),
        .pop_data  (frame_data),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: doc/ti_adc_frame_retimer.md
Name: ti_adc_frame_retimer

Overview:
- Parametrised successor to the fixed 8-way / 9-bit TI-ADC output retimer.
- Collects one sample per sub-ADC way into a frame, then queues complete frames in a small FIFO.
- Presents frames to the DSP back end with a valid/ready handshake.
- Sits between the sub-ADC output synchronisers, which deliver per-way valid pulses already in the core clock domain, and the deserialiser/DSP input.

Parameters:
ADC_WAYS, 8, number of interleaved sub-ADCs (2..16)
ADC_BITS, 9, bits per sub-ADC sample (4..16)
FIFO_DEPTH, 4, frame FIFO depth; power of two, at least 2
TIMEOUT, 32, cycles allowed from the first capture of a frame until frame completion
CNT_W, 16, width of drop counter and frame counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; when low, way_valid is ignored
msb_first  input  1  1: input bit[0] is the MSB, so reverse bits on capture; 0: bit[ADC_BITS-1] is the MSB
way_valid  input  ADC_WAYS  one-cycle sample strobe per way
way_data  input  ADC_WAYS*ADC_BITS  per-way sample; way k occupies bits [k*ADC_BITS +: ADC_BITS]
frame_ready  input  1  consumer ready
frame_valid  output  1  FIFO head valid
frame_data  output  ADC_WAYS*ADC_BITS  FIFO head frame; way 0 is in the LSBs
frame_cnt  output  CNT_W  count of frames pushed; wraps
drop_cnt  output  CNT_W  count of frames dropped on FIFO full; saturates
err_clr  input  1  clears the sticky error flags
err_missing  output  1  sticky; a partial frame timed out
err_dup  output  1  sticky; a way strobed twice within one frame
err_ovf  output  1  sticky; a complete frame was dropped because the FIFO was full

Behaviour:
- Reset: every output is 0; FIFO empty; state IDLE; capture mask and timer cleared.
- Capture: when en=1 and way_valid[k]=1 and captured[k]=0, write way_data slice k (bit-reversed if msb_first) into slot k and set captured[k].
- Duplicate strobe: way_valid[k] with captured[k]=1 is ignored (slot keeps its first sample) and sets err_dup.
- State machine has two states:
  - IDLE: no capture bits set, timer held at 0. Any accepted capture goes to COLLECT with timer=1. If the accepted strobes cover all ways in one cycle, the frame completes immediately and the state stays IDLE.
  - COLLECT: timer increments each cycle. When captured OR incoming-accepted equals all-ones, the frame completes: push it, clear the mask, go to IDLE. If timer reaches TIMEOUT without completion: discard the partial frame, clear the mask, set err_missing, go to IDLE. Strobes arriving in the timeout cycle are discarded with it.
- Push: frame_cnt increments on every successful push.
  - If the FIFO is full and no pop occurs in that cycle, the frame is dropped, drop_cnt increments (saturating) and err_ovf is set.
  - A push and a pop in the same cycle on a full FIFO both succeed.
- Latency: frame_valid rises on the cycle after the completing capture edge.
- Output handshake:
  - Pop on frame_valid & frame_ready.
  - frame_data is stable while frame_valid=1 and frame_ready=0.
  - FIFO pointers wrap modulo FIFO_DEPTH; a full/empty bit distinguishes wrapped pointers.
- en low mid-frame: no new captures occur, but the timer keeps running, so an incomplete frame times out.
- Errors: err_clr clears all sticky flags. If err_clr and a new error event occur in the same cycle, the flag stays set.
- rst_n asserted mid-frame: immediate return to the reset state; the partial frame and FIFO contents are lost.

Optional Feature:
- Macro TI_ADC_FRAME_OFFSET_EN.
- With the macro defined:
  - Extra input way_offset (ADC_WAYS*ADC_BITS, signed two's-complement per way) and extra input offset_bypass (1 bit).
  - Each captured sample, interpreted as offset-binary, is converted to signed, has way_offset[k] subtracted, and is saturated to ADC_BITS signed.
  - The conversion happens at capture time, so latency is unchanged.
  - offset_bypass=1 skips the subtraction but still converts to signed.
- Without the macro: raw unsigned samples pass through unmodified and neither port exists.

Decomposition:
- Package ti_adc_pkg holds:
  - default constants for ADC_WAYS, ADC_BITS, FIFO_DEPTH
  - the state enum typedef {IDLE, COLLECT}
  - a bit-reverse function
  - a signed saturate function
- One sub-module, ti_adc_frame_fifo: parametrised synchronous FIFO with full/empty outputs, reused for other ADC streams.

Test Plan:
- All 8 ways strobed in one cycle with way k = 9'h010+k, frame_ready=1 -> frame_valid next cycle, frame_data slot k = 0x010+k, frame_cnt=1.
- Ways strobed one per cycle in order 7..0, msb_first=1, data 9'b100000000 -> each slot = 9'b000000001; frame emitted after the way-0 strobe.
- Ways 0..6 strobed, way 7 never strobed -> err_missing=1 at cycle TIMEOUT, no frame emitted; the following full frame is emitted correctly.
- frame_ready=0, 6 complete frames -> 4 frames queued, drop_cnt=2, err_ovf=1; the FIFO drains in order once ready.
- Way 3 strobed twice within a frame with values 5 then 9 -> slot 3 = 5, err_dup=1; err_clr -> err_dup=0.
- rst_n pulsed low with 2 frames queued and 3 ways captured -> all outputs 0 immediately; a clean frame after release is emitted with frame_cnt=1.
